// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if
// Bus bundle shared by the CPU-side sequencer and its environment.
//   cpu_addr_out / cpu_data_out / cpu_wen / cpu_ren : CPU request
//   cpu_data_in / cpu_rdy                           : CPU response / stall
//   mem_addr_out / mem_data_out / mem_wen / mem_ren : memory-map request
//   mem_data_in                                     : memory-map read data
//   dma_busy / dma_done                             : DMA status
// slave  : the sequencer's view (drives mem_* and the CPU response).
// master : the environment's view (CPU plus memory map).
// ---------------------------------------------------------------------------
interface oam_dma_if;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_wen;
    logic        cpu_ren;
    logic [7:0]  cpu_data_in;
    logic        cpu_rdy;
    logic [15:0] mem_addr_out;
    logic [7:0]  mem_data_out;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_data_in;
    logic        dma_busy;
    logic        dma_done;

    modport slave (
        input  cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_data_in,
        output cpu_data_in, cpu_rdy, mem_addr_out, mem_data_out,
               mem_wen, mem_ren, dma_busy, dma_done
    );

    modport master (
        output cpu_addr_out, cpu_data_out, cpu_wen, cpu_ren, mem_data_in,
        input  cpu_data_in, cpu_rdy, mem_addr_out, mem_data_out,
               mem_wen, mem_ren, dma_busy, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Bus sequencer between the CPU and the memory map. While idle, CPU cycles
// pass straight through. A CPU write to TRIG_ADDR freezes the CPU and copies
// XFER_LEN bytes from page {data, 8'h00} to DEST_ADDR as alternating
// read/write cycles, with a one-cycle alignment slot so reads always fall on
// even (par==0) cycles.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : oam_dma_if.slave (CPU request/response, memory map, DMA status)
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN  = 256
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.slave  bus
);

    localparam int unsigned     IDX_W    = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_RD    = 3'd3,
        ST_WR    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_page;
    logic [7:0]       r_latch;
    logic             r_par;
    logic             r_done;

    logic             w_trig;
    logic             w_last;
    logic [7:0]       w_rd_lo;
    logic [15:0]      w_mem_addr;
    logic [7:0]       w_mem_data;
    logic             w_mem_wen;
    logic             w_mem_ren;
    logic [7:0]       w_cpu_din;
    logic             w_cpu_rdy;
    logic             w_busy;

    // Only an IDLE write to the trigger address starts a transfer.
    assign w_trig  = (r_state == ST_IDLE) && bus.cpu_wen && (bus.cpu_addr_out == TRIG_ADDR);
    assign w_last  = (r_idx == IDX_LAST);
    // Low address byte; idx never carries into the page.
    assign w_rd_lo = 8'(r_idx);

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                // par flips at the edge, so par==1 here means RD lands on par==0.
                if (r_par) begin
                    w_next = ST_RD;
                end else begin
                    w_next = ST_ALIGN;
                end
            end
            ST_ALIGN: w_next = ST_RD;
            ST_RD:    w_next = ST_WR;
            ST_WR: begin
                if (w_last) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RD;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Bus outputs: passthrough in IDLE, DMA traffic otherwise.
    always_comb begin
        w_mem_addr = 16'h0000;
        w_mem_data = 8'h00;
        w_mem_wen  = 1'b0;
        w_mem_ren  = 1'b0;
        w_cpu_din  = 8'h00;
        w_cpu_rdy  = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_mem_addr = bus.cpu_addr_out;
                w_mem_data = bus.cpu_data_out;
                w_mem_wen  = bus.cpu_wen;
                w_mem_ren  = bus.cpu_ren;
                w_cpu_din  = bus.mem_data_in;
                w_cpu_rdy  = 1'b1;
                w_busy     = 1'b0;
            end
            ST_RD: begin
                w_mem_addr = {r_page, w_rd_lo};
                w_mem_ren  = 1'b1;
            end
            ST_WR: begin
                w_mem_addr = DEST_ADDR;
                w_mem_data = r_latch;
                w_mem_wen  = 1'b1;
            end
            default: begin
                // HALT / ALIGN: bus idle, CPU frozen.
                w_mem_addr = 16'h0000;
            end
        endcase
    end

    assign bus.mem_addr_out = w_mem_addr;
    assign bus.mem_data_out = w_mem_data;
    assign bus.mem_wen      = w_mem_wen;
    assign bus.mem_ren      = w_mem_ren;
    assign bus.cpu_data_in  = w_cpu_din;
    assign bus.cpu_rdy      = w_cpu_rdy;
    assign bus.dma_busy     = w_busy;
    assign bus.dma_done     = r_done;

    // State, transfer index, source page, data latch, parity and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_page  <= 8'h00;
            r_latch <= 8'h00;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_par   <= ~r_par;
            r_done  <= (r_state == ST_WR) && w_last;
            if (w_trig) begin
                r_page <= bus.cpu_data_out;
            end
            if (r_state == ST_RD) begin
                r_latch <= bus.mem_data_in;
            end
            if (r_state == ST_WR) begin
                if (w_last) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    localparam int XFER = 256;

    logic clk = 1'b0;
    logic rst;
    logic ovr_en;
    logic [7:0] ovr_d;
    logic tb_par;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    oam_dma_if bus();

    oam_dma_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Source memory contents: page 02h holds i^5Ah, other pages a distinct pattern.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
        else return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    assign bus.mem_data_in = ovr_en ? ovr_d : src_byte(bus.mem_addr_out);

    // Reference parity: 0 in every cycle following a reset edge, then toggles.
    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wen;
        logic        ren;
        logic [7:0]  rdata;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_wen;
        logic        e_ren;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        bus.cpu_addr_out = a;
        bus.cpu_data_out = d;
        bus.cpu_wen      = w;
        bus.cpu_ren      = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Trigger a DMA on a cycle with the requested parity and follow it to the end
    // (or to a reset after rst_after writes when rst_after is nonzero).
    task automatic run_dma(input logic [7:0] page, input logic want_par,
                           input logic junk, input int rst_after);
        int guard = 0;
        int stall = 0, wr = 0, rd = 0, first_rd = 0;
        int bad_w = 0, bad_r = 0, bad_idle = 0, bad_busy = 0, bad_post = 0;
        logic ended = 1'b0;
        logic hit = 1'b0;
        while (tb_par != want_par && guard < 4) begin
            set_in(16'h0000, 8'h00, 1'b0, 1'b0);
            next_cycle();
            guard++;
        end
        set_in(16'h4014, page, 1'b1, 1'b0);
        @(negedge clk);
        check("trig_pass", 32'({bus.mem_wen, bus.mem_ren, bus.cpu_rdy, bus.mem_addr_out, bus.mem_data_out}),
              32'({1'b1, 1'b0, 1'b1, 16'h4014, page}));
        next_cycle();
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (junk && wr < XFER) set_in(16'h4014, 8'h07, 1'b1, 1'b1);
            else set_in(16'h0000, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (bus.cpu_rdy) begin
                ended = 1'b1;
                break;
            end
            stall++;
            if (!bus.dma_busy || bus.cpu_data_in != 8'h00 || bus.dma_done) bad_busy++;
            if (bus.mem_ren) begin
                if (first_rd == 0) first_rd = stall;
                if (bus.mem_addr_out != {page, 8'(rd)} || bus.mem_wen || bus.mem_data_out != 8'h00) bad_r++;
                rd++;
            end else if (bus.mem_wen) begin
                if (bus.mem_addr_out != 16'h2004 || bus.mem_data_out != src_byte({page, 8'(wr)})) bad_w++;
                wr++;
            end else if (bus.mem_addr_out != 16'h0000 || bus.mem_data_out != 8'h00) begin
                bad_idle++;
            end
            if (rst_after != 0 && wr == rst_after) begin
                hit = 1'b1;
                break;
            end
            next_cycle();
        end
        check("dma_wr_data", 32'(bad_w), 32'd0);
        check("dma_rd_addr", 32'(bad_r), 32'd0);
        check("dma_idle_bus", 32'(bad_idle), 32'd0);
        check("dma_busy_din", 32'(bad_busy), 32'd0);
        check("dma_first_rd", 32'(first_rd), want_par ? 32'd3 : 32'd2);
        if (rst_after != 0) begin
            check("rst_reached", 32'(hit), 32'd1);
            check("rst_wr_count", 32'(wr), 32'(rst_after));
            next_cycle();
            rst = 1'b1;
            set_in(16'h0000, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            check("rst_cycle_nowen", 32'(bus.mem_wen), 32'd0);
            next_cycle();
            rst = 1'b0;
            @(negedge clk);
            check("rst_after_state", 32'({bus.cpu_rdy, bus.dma_busy, bus.dma_done, bus.mem_wen}), 32'b1000);
            for (int k = 0; k < 4; k++) begin
                next_cycle();
                @(negedge clk);
                if (bus.mem_wen || bus.dma_done || !bus.cpu_rdy) bad_post++;
            end
            check("rst_quiet", 32'(bad_post), 32'd0);
            next_cycle();
        end else begin
            check("dma_ended", 32'(ended), 32'd1);
            check("dma_stall", 32'(stall), want_par ? 32'd514 : 32'd513);
            check("dma_wr_count", 32'(wr), 32'(XFER));
            check("dma_rd_count", 32'(rd), 32'(XFER));
            check("dma_done_pulse", 32'({bus.dma_done, bus.dma_busy}), 32'b10);
            next_cycle();
            set_in(16'h0000, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            check("dma_done_once", 32'({bus.dma_done, bus.cpu_rdy}), 32'b01);
            next_cycle();
        end
    endtask

    initial begin
        vecs[0] = '{16'h0005, 8'h00, 1'b0, 1'b1, 8'hA5, 16'h0005, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{16'h0010, 8'h3C, 1'b1, 1'b0, 8'h00, 16'h0010, 8'h3C, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{16'h1234, 8'h55, 1'b0, 1'b0, 8'h77, 16'h1234, 8'h55, 1'b0, 1'b0, 8'h77};
        vecs[3] = '{16'h4014, 8'h00, 1'b0, 1'b1, 8'h11, 16'h4014, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[4] = '{16'h4015, 8'h02, 1'b1, 1'b0, 8'h22, 16'h4015, 8'h02, 1'b1, 1'b0, 8'h22};
        vecs[5] = '{16'h2004, 8'h09, 1'b1, 1'b0, 8'h33, 16'h2004, 8'h09, 1'b1, 1'b0, 8'h33};
        vecs[6] = '{16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h5A, 16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h5A};

        rst = 1'b1;
        ovr_en = 1'b0;
        ovr_d = 8'h00;
        set_in(16'h0000, 8'h00, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_state", 32'({bus.cpu_rdy, bus.dma_busy, bus.dma_done, bus.mem_wen, bus.mem_ren}), 32'b10000);
        next_cycle();

        // A trigger while reset is asserted must not start a DMA.
        set_in(16'h4014, 8'h02, 1'b1, 1'b0);
        next_cycle();
        rst = 1'b0;
        set_in(16'h0000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("trig_in_reset", 32'({bus.cpu_rdy, bus.dma_busy, bus.dma_done}), 32'b100);
        next_cycle();

        // IDLE passthrough vectors, applied back to back.
        ovr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].ren);
            ovr_d = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("pass%0d_bus", i),
                  32'({bus.mem_addr_out, bus.mem_data_out, bus.mem_wen, bus.mem_ren}),
                  32'({vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_wen, vecs[i].e_ren}));
            check($sformatf("pass%0d_cpu", i),
                  32'({bus.cpu_data_in, bus.cpu_rdy, bus.dma_busy}),
                  32'({vecs[i].e_din, 1'b1, 1'b0}));
            next_cycle();
        end
        ovr_en = 1'b0;
        set_in(16'h0000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("no_false_trigger", 32'({bus.cpu_rdy, bus.dma_busy}), 32'b10);
        next_cycle();

        run_dma(8'h02, 1'b1, 1'b0, 0);   // even-aligned: ALIGN inserted, 514
        run_dma(8'h02, 1'b0, 1'b0, 0);   // odd-aligned: 513
        run_dma(8'hFF, 1'b1, 1'b0, 0);   // page FFh, no wrap into 0000h
        run_dma(8'h02, 1'b0, 1'b1, 0);   // CPU junk during DMA is ignored
        run_dma(8'h02, 1'b1, 1'b0, 100); // reset after the 100th write
        run_dma(8'h02, 1'b0, 1'b0, 0);   // fresh DMA restarts from idx 0

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Bus sequencer between the CPU core and the memory/IO map. In IDLE it passes CPU transactions straight through to memory. A CPU write to the SPR-RAM DMA register (4014h) stalls the CPU and copies 256 bytes from CPU page {data,8'h00} to SPR-RAM Data (2004h), as alternating read/write bus cycles. It adds the NES 1-cycle parity alignment.

Parameters:
TRIG_ADDR, 16'h4014, CPU write address that starts a DMA
DEST_ADDR, 16'h2004, write target for every DMA byte
XFER_LEN, 256, bytes per DMA; power of two, 2..256

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_addr_out  in  16  CPU address
cpu_data_out  in  8  CPU write data
cpu_wen  in  1  CPU write enable
cpu_ren  in  1  CPU read enable
cpu_data_in  out  8  read data returned to CPU
cpu_rdy  out  1  1 = CPU may advance; 0 = CPU frozen
mem_addr_out  out  16  address to memory map
mem_data_out  out  8  write data to memory map
mem_wen  out  1  memory write enable
mem_ren  out  1  memory read enable
mem_data_in  in  8  memory read data, combinational in the same cycle as mem_ren
dma_busy  out  1  DMA in progress
dma_done  out  1  1-cycle pulse after the last write

Behaviour:
- Reset state:
  - FSM is IDLE.
  - idx=0, page=0, latch=0, par=0.
  - dma_busy=0, dma_done=0.
- par toggles every cycle after reset (0,1,0,...).
- States: IDLE, HALT, ALIGN, RD, WR.
- IDLE:
  - mem_* = cpu_* combinationally.
  - cpu_data_in = mem_data_in.
  - cpu_rdy=1.
- Trigger: in IDLE, cpu_wen=1 and cpu_addr_out==TRIG_ADDR.
  - The write still passes through to memory that cycle.
  - page <= cpu_data_out.
  - Next state is HALT.
  - cpu_ren, or a write to any other address, does not trigger.
- HALT (1 cycle), all mem enables 0:
  - If par==1, next state is RD.
  - If par==0, next state is ALIGN.
  - Result: every RD lands on a par==0 cycle.
- ALIGN (1 cycle), enables 0, next state is RD.
- RD:
  - mem_addr_out = {page, idx[7:0]}, mem_ren=1.
  - latch <= mem_data_in at the clock edge.
  - Next state is WR.
- WR:
  - mem_addr_out = DEST_ADDR, mem_data_out = latch, mem_wen=1.
  - idx <= idx+1.
  - If idx==XFER_LEN-1: idx <= 0, next state is IDLE, dma_done=1 on the following cycle.
  - Otherwise next state is RD.
- Addressing: {page, idx} forms the full 16-bit address. No carry into page; idx wraps at XFER_LEN.
- In every state except IDLE:
  - cpu_rdy=0, dma_busy=1, cpu_data_in=8'h00.
  - CPU inputs are ignored, including a further TRIG_ADDR write.
- Stall length: from the cycle after the trigger to the last WR inclusive is 1 + align + 2*XFER_LEN.
  - align is 0 or 1.
  - With default XFER_LEN this is 513 or 514 cycles.
  - cpu_rdy returns to 1 in the cycle after the last WR.
- In non-IDLE states, mem_data_out is 0 outside WR, and mem_addr_out is 0 in HALT/ALIGN.
- Reset mid-DMA:
  - Immediately IDLE on the next cycle. No dma_done pulse; no further mem_wen.
  - Memory contents already written are kept.
- Trigger in the same cycle as rst=1 is ignored; reset wins.

Test Plan:
- Passthrough: in IDLE, CPU read of 0005h with mem_data_in=8'hA5 -> mem_ren=1, mem_addr_out=0005h, cpu_data_in=A5 in the same cycle, cpu_rdy=1. CPU write of 8'h3C to 0010h -> mem_wen=1 with the same addr/data.
- Even-aligned DMA: RAM 0200h..02FFh holds i^8'h5A. Write 8'h02 to 4014h on a par==1 cycle, so HALT sees par==0 -> ALIGN is inserted. Expect cpu_rdy=0 for exactly 514 cycles, 256 writes to 2004h with data i^5A in order, dma_done once, then cpu_rdy=1.
- Odd-aligned DMA: same stimulus but the trigger falls on a par==0 cycle -> no ALIGN, stall of exactly 513 cycles. The first RD addr is 0200h on the 2nd cycle after the trigger.
- Page wrap: trigger with page 8'hFF -> read addresses FF00h..FFFFh, never 0000h. The 4014h write itself is visible on the mem bus in the trigger cycle.
- Ignored inputs: during the DMA, drive cpu_wen=1 to 4014h with data 8'h07 and cpu_ren=1 -> no restart, page unchanged, mem bus shows only DMA traffic, cpu_data_in=0.
- Reset mid-DMA: assert rst after the 100th WR -> next cycle IDLE, cpu_rdy=1, dma_busy=0, dma_done=0, no 101st write. A new trigger afterwards starts again from idx 0.
